// File: rtl/booth_mac_accum_if.sv
// Handshake bundle between the Booth multiplier, the MAC back end and the result consumer.
interface booth_mac_accum_if #(
  parameter int ACC_W   = 12,
  parameter int COUNT_W = 6
);
  logic               clr;
  logic [COUNT_W-1:0] len;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         prod;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   acc_out;
  logic               ovf;

  modport slave (
    input  clr, len, in_valid, prod, out_ready,
    output in_ready, out_valid, acc_out, ovf
  );

  modport master (
    output clr, len, in_valid, prod, out_ready,
    input  in_ready, out_valid, acc_out, ovf
  );
endinterface

// File: rtl/booth_mac_accum.sv
// Signed multiply-accumulate back end: sums len Booth products into an ACC_W accumulator.
// Define BOOTH_MAC_SAT_EN for saturating accumulation; default is two's-complement wrap.
module booth_mac_accum #(
  parameter int ACC_W   = 12,
  parameter int COUNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  booth_mac_accum_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [COUNT_W-1:0] ONE     = COUNT_W'(1);
  localparam logic [ACC_W-1:0]   ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]   ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [COUNT_W-1:0] r_rem;
  logic               r_ovf;
  logic               r_out_valid;

  logic               w_in_ready;
  logic               w_accept;
  logic [ACC_W-1:0]   w_prod_ext;
  logic [ACC_W-1:0]   w_sum;
  logic               w_add_ovf;
  logic [ACC_W-1:0]   w_acc_next;

  assign w_prod_ext[7:0] = bus.prod;
  generate
    for (genvar gi = 8; gi < ACC_W; gi++) begin : g_sext
      assign w_prod_ext[gi] = bus.prod[7];
    end
  endgenerate

  assign w_in_ready = (r_state != DONE);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_sum      = r_acc + w_prod_ext;
  // Same-sign addends producing an opposite-sign sum means the true sum left the range.
  assign w_add_ovf  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                      (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

`ifdef BOOTH_MAC_SAT_EN
  assign w_acc_next = w_add_ovf ? (r_acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : w_sum;
`else
  assign w_acc_next = w_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_rem       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (bus.clr) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_rem       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc <= w_prod_ext;
            r_ovf <= 1'b0;
            // A zero length behaves as a single-term result.
            r_rem <= (bus.len == '0) ? '0 : bus.len - ONE;
            if (bus.len <= ONE) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_acc <= w_acc_next;
            r_ovf <= r_ovf | w_add_ovf;
            r_rem <= r_rem - ONE;
            if (r_rem == ONE) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.acc_out   = r_acc;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_booth_mac_accum.sv
// Scoreboard bench for booth_mac_accum: directed cases plus randomized dot products.
module tb_booth_mac_accum;
  localparam int ACC_W   = 12;
  localparam int COUNT_W = 6;
  localparam int S_MAX   = (1 << (ACC_W - 1)) - 1;
  localparam int S_MIN   = -(1 << (ACC_W - 1));

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic             ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 1;  // 0: hold low, 1: random, 2: force high
  exp_t exp_q[$];

  booth_mac_accum_if #(.ACC_W(ACC_W), .COUNT_W(COUNT_W)) bus ();

  booth_mac_accum #(.ACC_W(ACC_W), .COUNT_W(COUNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer sum with wrap or clamp applied after each added term.
  function automatic exp_t model(input logic [7:0] ps[$]);
    exp_t r;
    int   s;
    int   t;
    s = 0;
    r.ov = 1'b0;
    for (int i = 0; i < ps.size(); i++) begin
      t = s + int'($signed(ps[i]));
      if (t > S_MAX) begin
        r.ov = 1'b1;
`ifdef BOOTH_MAC_SAT_EN
        t = S_MAX;
`else
        t = t - (1 << ACC_W);
`endif
      end else if (t < S_MIN) begin
        r.ov = 1'b1;
`ifdef BOOTH_MAC_SAT_EN
        t = S_MIN;
`else
        t = t + (1 << ACC_W);
`endif
      end
      s = t;
    end
    r.acc = ACC_W'(s);
    return r;
  endfunction

  // Holds in_valid until the term is accepted; caller is just past a rising edge.
  task automatic wait_accept();
    logic rd;
    int   cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      rd = bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end while (!rd && cyc < 300);
    if (!rd) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: in_ready stuck at 0 required 1 at %0t", $time);
    end
  endtask

  task automatic run_result(input int len_v, input logic [7:0] ps[$], input bit bubbles);
    exp_t e;
    for (int i = 0; i < ps.size(); i++) begin
      bus.in_valid = 1'b1;
      bus.prod     = ps[i];
      bus.len      = (i == 0) ? COUNT_W'(len_v) : COUNT_W'($urandom);
      wait_accept();
      bus.in_valid = 1'b0;
      if (bubbles && ($urandom_range(0, 3) == 0) && (i != ps.size() - 1)) begin
        @(posedge clk);
        #1;
      end
    end
    chk("out_valid_latency", 32'(bus.out_valid), 32'd1);
    e = model(ps);
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  always begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       bus.out_ready = 1'b0;
      2:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom);
    endcase
  end

  // Monitor: pops the scoreboard on every output handshake, checks hold stability while stalled.
  initial begin
    exp_t e;
    logic stall_prev;
    logic [ACC_W-1:0] acc_prev;
    logic ovf_prev;
    stall_prev = 1'b0;
    acc_prev = '0;
    ovf_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (stall_prev) begin
          chk("hold_acc", 32'(bus.acc_out), 32'(acc_prev));
          chk("hold_ovf", 32'(bus.ovf), 32'(ovf_prev));
        end
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_result: acc_out %0h with no result expected", bus.acc_out);
          end else begin
            e = exp_q.pop_front();
            $display("result acc_out=%03h ovf=%0b expected acc=%03h ovf=%0b",
                     bus.acc_out, bus.ovf, e.acc, e.ov);
            chk("acc_out", 32'(bus.acc_out), 32'(e.acc));
            chk("ovf", 32'(bus.ovf), 32'(e.ov));
          end
        end
      end
      stall_prev = !rst && bus.out_valid && !bus.out_ready;
      acc_prev   = bus.acc_out;
      ovf_prev   = bus.ovf;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ps[$];
    exp_t       e;
    int         len_v;
    int         n;
    bus.clr      = 1'b0;
    bus.len      = '0;
    bus.in_valid = 1'b0;
    bus.prod     = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_acc_out", 32'(bus.acc_out), 32'h000);
    chk("reset_ovf", 32'(bus.ovf), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Three terms back-to-back: -6 + 12 + 9 = 15
    ps = '{8'hFA, 8'h0C, 8'h09};
    run_result(3, ps, 1'b0);
    drain();

    // Backpressure: result held for 5 cycles with out_ready low
    rdy_mode = 0;
    @(posedge clk);
    #1;
    ps = '{8'h21, 8'hF0, 8'h03};
    run_result(3, ps, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_acc_out", 32'(bus.acc_out), 32'h014);
    end
    @(posedge clk);
    #1;
    rdy_mode = 2;
    @(posedge clk);
    #1;
    rdy_mode = 0;
    @(negedge clk);
    chk("bp_released_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_released_out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    rdy_mode = 1;
    ps = '{8'h80};
    run_result(1, ps, 1'b0);
    drain();

    // Overflow: 17 x 127
    ps = {};
    for (int i = 0; i < 17; i++) ps.push_back(8'h7F);
    run_result(17, ps, 1'b0);
    drain();

    // Abort: clr with a third product offered
    ps = '{8'h10, 8'h10};
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.prod     = ps[i];
      bus.len      = COUNT_W'(4);
      wait_accept();
    end
    bus.prod = 8'h10;
    bus.clr  = 1'b1;
    @(posedge clk);
    #1;
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_acc_out", 32'(bus.acc_out), 32'h000);
    chk("clr_ovf", 32'(bus.ovf), 32'd0);
    chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("clr_in_ready", 32'(bus.in_ready), 32'd1);
    ps = '{8'h05};
    run_result(1, ps, 1'b0);
    drain();

    // len = 0 behaves as one term
    ps = '{8'hFF};
    run_result(0, ps, 1'b0);
    drain();

    // Asynchronous reset mid-accumulation
    bus.in_valid = 1'b1;
    bus.prod     = 8'h33;
    bus.len      = COUNT_W'(5);
    wait_accept();
    wait_accept();
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_acc_out", 32'(bus.acc_out), 32'h000);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized dot products with bubbles, random ready and large-magnitude runs
    for (int k = 0; k < 40; k++) begin
      ps = {};
      if ($urandom_range(0, 4) == 0) begin
        len_v = $urandom_range(16, 30);
        n = len_v;
        for (int i = 0; i < n; i++)
          ps.push_back(($urandom_range(0, 1) != 0) ? 8'($urandom_range(8'h60, 8'h7F))
                                                    : 8'($urandom_range(8'h80, 8'hA0)));
      end else begin
        len_v = $urandom_range(0, 9);
        n = (len_v == 0) ? 1 : len_v;
        for (int i = 0; i < n; i++) ps.push_back(8'($urandom));
      end
      run_result(len_v, ps, 1'b1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
